// File: rtl/i_memory_stage.sv
// i_memory_stage: MIPS MEM stage with word-addressed data memory, branch resolve
// and the MEM/WB pipeline latch.
module i_memory_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  wb_ctlout,
    input  logic [2:0]  m_ctlout,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2out,
    input  logic [4:0]  five_bit_muxout,
    output logic        PCSrc,
    output logic [1:0]  mem_wb_ctl,
    output logic [31:0] mem_read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_write_reg,
    output logic        misaligned
);
    logic [ADDR_W-1:0] w_idx;
    logic              w_aligned;
    logic              w_rd;
    logic              w_wr;
    logic              w_unused;
    logic [31:0]       r_mem [DEPTH] = '{default: 32'h0};
    logic [1:0]        r_ctl;
    logic [31:0]       r_rdata;
    logic [31:0]       r_alu;
    logic [4:0]        r_wreg;
    logic              r_mis;

    // upper address bits are deliberately dropped so accesses wrap modulo DEPTH
    assign w_idx     = alu_result[ADDR_W+1:2];
    assign w_unused  = ^alu_result[31:ADDR_W+2];
    assign w_aligned = alu_result[1:0] == 2'b00;
    assign w_rd      = m_ctlout[1];
    assign w_wr      = m_ctlout[0];
    assign PCSrc     = m_ctlout[2] & zero;

    always_ff @(posedge clk)
        if (reset && w_wr && w_aligned)
            r_mem[w_idx] <= rdata2out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctl   <= 2'b0;
            r_rdata <= 32'h0;
            r_alu   <= 32'h0;
            r_wreg  <= 5'h0;
            r_mis   <= 1'b0;
        end else begin
            r_ctl   <= wb_ctlout;
            r_rdata <= (w_rd && w_aligned) ? r_mem[w_idx] : 32'h0;
            r_alu   <= alu_result;
            r_wreg  <= five_bit_muxout;
            r_mis   <= (w_rd || w_wr) && !w_aligned;
        end
    end

    assign mem_wb_ctl     = r_ctl;
    assign mem_read_data  = r_rdata;
    assign mem_alu_result = r_alu;
    assign mem_write_reg  = r_wreg;
    assign misaligned     = r_mis;
endmodule
